// File: rtl/truth_table_sequencer.sv
// Built-in self-test sequencer: sweeps every WIDTH-bit input vector through an
// external combinational datapath, captures the response into a truth table and
// compares it against the golden EXPECTED pattern.
module truth_table_sequencer #(
  parameter int unsigned              WIDTH    = 3,
  parameter int unsigned              SETTLE   = 1,
  parameter logic [(2**WIDTH)-1:0]    EXPECTED = 8'h41
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(2**WIDTH)-1:0]  table_out,
  output logic [(2**WIDTH)-1:0]  err_mask,
  output logic                   pass
);

  localparam int unsigned NV = 2**WIDTH;
  // Counter only ever holds 0..SETTLE, so it is sized for SETTLE and never wraps.
  localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [WIDTH-1:0] LAST_VEC = '1;
  localparam logic [CW-1:0]    SETTLE_V = CW'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [NV-1:0]    table_q,    table_d;
  logic [NV-1:0]    err_q,      err_d;
  logic             pass_q,     pass_d;

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    table_d    = table_q;
    err_d      = err_q;
    pass_d     = pass_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HOLD;
          data_out_d = '0;
          cnt_d      = SETTLE_V;
          table_d    = '0;
          busy_d     = 1'b1;
          err_d      = '0;
          pass_d     = 1'b0;
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        table_d[data_out_q] = f_in;
        if (data_out_q == LAST_VEC) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          data_out_d = data_out_q + WIDTH'(1);
          cnt_d      = SETTLE_V;
          state_d    = HOLD;
        end
      end

      FINISH: begin
        busy_d     = 1'b0;
        err_d      = table_q ^ EXPECTED;
        pass_d     = (table_q == EXPECTED);
        data_out_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      table_q    <= table_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
    end
  end

  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign err_mask  = err_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed self-checking bench: default-parameter sequencer plus a SETTLE=0
// instance driven by a combinational or one-cycle-delayed datapath model.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [2:0] data0, data1;
  logic       f_in0, f_in1, f_del;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tbl0, tbl1, err0, err1;

  int mode0 = 0;   // 0: real datapath, 1: tied 0, 2: tied 1
  int mode1 = 0;   // 0: real datapath, 1: datapath with 1-cycle output delay
  int sel   = 0;   // which instance the checking view follows

  int checks   = 0;
  int failures = 0;

  logic [2:0] d_data;
  logic       d_busy, d_done, d_pass;
  logic [7:0] d_tbl, d_err;

  always #5 clk = ~clk;

  function automatic logic ref_f(input logic [2:0] v);
    return ~((v[2] ^ v[1]) | v[0]);
  endfunction

  always_comb begin
    f_in0 = (mode0 == 0) ? ref_f(data0) : (mode0 == 1) ? 1'b0 : 1'b1;
    f_in1 = (mode1 == 0) ? ref_f(data1) : f_del;
  end

  always @(posedge clk) f_del <= ref_f(data1);

  always_comb begin
    d_data = (sel == 0) ? data0 : data1;
    d_busy = (sel == 0) ? busy0 : busy1;
    d_done = (sel == 0) ? done0 : done1;
    d_pass = (sel == 0) ? pass0 : pass1;
    d_tbl  = (sel == 0) ? tbl0  : tbl1;
    d_err  = (sel == 0) ? err0  : err1;
  end

  truth_table_sequencer #(.WIDTH(3), .SETTLE(1), .EXPECTED(8'h41)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_out(data0), .f_in(f_in0),
    .busy(busy0), .done(done0), .table_out(tbl0), .err_mask(err0), .pass(pass0)
  );

  truth_table_sequencer #(.WIDTH(3), .SETTLE(0), .EXPECTED(8'h41)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_out(data1), .f_in(f_in1),
    .busy(busy1), .done(done1), .table_out(tbl1), .err_mask(err1), .pass(pass1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (d_data !== 3'd0 || d_busy !== 1'b0 || d_done !== 1'b0 ||
        d_tbl !== 8'h00 || d_err !== 8'h00 || d_pass !== 1'b0) begin
      failures++;
      $display("FAIL %s: data=%0d busy=%b done=%b table=%h err=%h pass=%b, required all zero",
               name, d_data, d_busy, d_done, d_tbl, d_err, d_pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    sel = 0; check_idle_zero("reset_dut0");
    sel = 1; check_idle_zero("reset_dut1");
    rst = 1'b0;
    sel = 0;
  endtask

  // One full sweep; per = SETTLE+2 cycles per vector.
  task automatic run_sweep(input int per, input logic [7:0] exp_tbl,
                           input logic [7:0] exp_err, input logic exp_pass,
                           input string name);
    int total;
    total = 8 * per;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int c = 0; c < total; c++) begin
      checks++;
      if (d_busy !== 1'b1 || d_done !== 1'b0 || d_data !== 3'(c / per)) begin
        failures++;
        $display("FAIL %s_step c=%0d: busy=%b done=%b data=%0d, required busy=1 done=0 data=%0d",
                 name, c, d_busy, d_done, d_data, c / per);
      end
      tick();
    end
    checks++;
    if (d_done !== 1'b1 || d_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_done c=%0d: done=%b busy=%b, required 1 1", name, total, d_done, d_busy);
    end
    tick();
    checks++;
    if (d_done !== 1'b0 || d_busy !== 1'b0 || d_data !== 3'd0 ||
        d_tbl !== exp_tbl || d_err !== exp_err || d_pass !== exp_pass) begin
      failures++;
      $display("FAIL %s_result: done=%b busy=%b data=%0d table=%h err=%h pass=%b, required 0 0 0 %h %h %b",
               name, d_done, d_busy, d_data, d_tbl, d_err, d_pass, exp_tbl, exp_err, exp_pass);
    end
    tick();
    tick();
    tick();
    checks++;
    if (d_tbl !== exp_tbl || d_err !== exp_err || d_pass !== exp_pass || d_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_hold: table=%h err=%h pass=%b done=%b, required %h %h %b 0",
               name, d_tbl, d_err, d_pass, d_done, exp_tbl, exp_err, exp_pass);
    end
  endtask

  task automatic test_sweeps();
    sel = 0;
    mode0 = 0; run_sweep(3, 8'h41, 8'h00, 1'b1, "good");
    mode0 = 1; run_sweep(3, 8'h00, 8'h41, 1'b0, "tie0");
    mode0 = 2; run_sweep(3, 8'hFF, 8'hBE, 1'b0, "tie1");
    mode0 = 0;
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    sel = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c == 5 || c == 23) start0 = 1'b1;
      if (c == 6) start0 = 1'b0;
      if (d_done === 1'b1) dones++;
      if (c == 24) begin
        checks++;
        if (d_done !== 1'b1) begin
          failures++;
          $display("FAIL b2b_done24: done=%b, required 1", d_done);
        end
      end
      tick();
    end
    // c = 26: new sweep accepted on the first IDLE edge.
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d pulses, required 1", dones);
    end
    checks++;
    if (d_busy !== 1'b1 || d_data !== 3'd0 || d_tbl !== 8'h00 || d_pass !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b data=%0d table=%h pass=%b, required 1 0 00 0",
               d_busy, d_data, d_tbl, d_pass);
    end
    start0 = 1'b0;
    for (int c = 26; c < 50; c++) tick();
    checks++;
    if (d_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_done: done=%b, required 1", d_done);
    end
    tick();
    checks++;
    if (d_pass !== 1'b1 || d_tbl !== 8'h41 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_result: pass=%b table=%h busy=%b, required 1 41 0",
               d_pass, d_tbl, d_busy);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    sel = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if (d_data !== 3'd4 || d_tbl === 8'h00) begin
      failures++;
      $display("FAIL abort_pre: data=%0d table=%h, required data=4 table nonzero", d_data, d_tbl);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("abort_reset");
    for (int c = 0; c < 30; c++) begin
      if (d_done === 1'b1 || d_busy === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d active cycles after abort, required 0", dones);
    end
    run_sweep(3, 8'h41, 8'h00, 1'b1, "after_abort");
  endtask

  task automatic test_settle0();
    sel = 1;
    mode1 = 0; run_sweep(2, 8'h41, 8'h00, 1'b1, "s0_comb");
    mode1 = 1; run_sweep(2, 8'h41, 8'h00, 1'b1, "s0_delay");
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_sweeps();
    test_back_to_back();
    test_reset_abort();
    test_settle0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
